id_ex_control_stage: RTL and testbench

Decode-side counterpart of the EX-stage ALU operation decoder. It turns the IF/ID instruction word into the main control bundle, including the 2-bit ALUOp and the 4-bit Funct code that the EX stage consumes. It registers that bundle into the ID/EX pipeline slot. It also detects load-use hazards, inserts one-cycle bubbles and honours branch flushes.

---
 rtl/id_ex_control_stage_pkg.sv | 51 +++++
 rtl/id_ex_control_stage_main_control_decoder.sv | 64 ++++++
 rtl/id_ex_control_stage.sv | 108 ++++++++++
 tb/tb_id_ex_control_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_control_stage_pkg.sv
// Shared decode types and constants for the ID/EX control stage.
// Holds opcodes, ALUOp/Funct encodings and the control bundle struct.
package id_ex_control_stage_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_FUNCT  = 2'b10
    } alu_op_e;

    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SLL = 4'b0001;
    localparam logic [3:0] FUNCT_SUB = 4'b1000;
    localparam logic [3:0] FUNCT_AND = 4'b0111;
    localparam logic [3:0] FUNCT_OR  = 4'b0110;

    typedef struct packed {
        alu_op_e    alu_op;
        logic [3:0] funct;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        alu_op:     ALUOP_ADD,
        funct:      4'b0000,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        branch:     1'b0
    };

    // Only formats that actually read rs2 may create an rs2 load-use hazard.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_STORE) ||
               (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_ex_control_stage_main_control_decoder.sv
// Combinational main control decoder: opcode/funct fields to bundle.
// Flags encodings the EX stage cannot execute as illegal.
module main_control_decoder
    import id_ex_control_stage_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       bit30,
    output ctrl_t      ctrl,
    output logic       illegal
);

    logic [3:0] rfunct;

    assign rfunct = {bit30, funct3};

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        unique case (opcode)
            OP_R: begin
                ctrl.alu_op    = ALUOP_FUNCT;
                ctrl.funct     = rfunct;
                ctrl.reg_write = 1'b1;
                unique case (rfunct)
                    FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR: ;
                    default: illegal = 1'b1;
                endcase
            end
            OP_I_ALU: begin
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                // bit30 is immediate data here, so it never reaches Funct
                unique case (funct3)
                    3'b000:  ctrl.funct = FUNCT_ADD;
                    3'b001:  ctrl.funct = FUNCT_SLL;
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.funct      = FUNCT_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            OP_STORE: begin
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.funct     = FUNCT_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.alu_op = ALUOP_BRANCH;
                ctrl.funct  = rfunct;
                ctrl.branch = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_control_stage.sv
// ID/EX control register with load-use stall and flush handling.
// Optional ILLEGAL_TRAP_EN adds the ex_illegal output.
module id_ex_control_stage
    import id_ex_control_stage_pkg::*;
#(
    parameter int XLEN_IDX = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [31:0]         id_instr,
    input  logic                flush,
    output logic                stall_out,
    output logic                ex_valid,
    output logic [1:0]          ex_ALUOp,
    output logic [3:0]          ex_Funct,
    output logic                ex_RegWrite,
    output logic                ex_MemRead,
    output logic                ex_MemWrite,
    output logic                ex_MemtoReg,
    output logic                ex_ALUSrc,
    output logic                ex_Branch,
    output logic [XLEN_IDX-1:0] ex_rs1,
    output logic [XLEN_IDX-1:0] ex_rs2,
    output logic [XLEN_IDX-1:0] ex_rd
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                ex_illegal
`endif
);

    ctrl_t               dec_ctrl;
    logic                dec_illegal;
    ctrl_t               ctrl_q;
    logic [XLEN_IDX-1:0] rs1;
    logic [XLEN_IDX-1:0] rs2;
    logic [XLEN_IDX-1:0] rd;
    logic                rs1_hit;
    logic                rs2_hit;
    logic                load_in_ex;
    logic                bubble;
    logic                unused_bits;

    assign rs1 = XLEN_IDX'(id_instr[19:15]);
    assign rs2 = XLEN_IDX'(id_instr[24:20]);
    assign rd  = XLEN_IDX'(id_instr[11:7]);

    assign unused_bits = ^{id_instr[31], id_instr[29:25]};

    main_control_decoder u_dec (
        .opcode  (id_instr[6:0]),
        .funct3  (id_instr[14:12]),
        .bit30   (id_instr[30]),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign load_in_ex = ex_valid && ctrl_q.mem_read && (ex_rd != '0);
    assign rs1_hit    = (ex_rd == rs1);
    assign rs2_hit    = (ex_rd == rs2) && uses_rs2(id_instr[6:0]);

    // A flush discards the consumer, so it can never be the cause of a stall.
    assign stall_out = load_in_ex && id_valid && !flush &&
                       (rs1_hit || rs2_hit);

    assign bubble = flush || stall_out || !id_valid || dec_illegal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid <= 1'b0;
            ctrl_q   <= CTRL_BUBBLE;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
        end else begin
            ex_rs1 <= rs1;
            ex_rs2 <= rs2;
            ex_rd  <= rd;
            if (bubble) begin
                ex_valid <= 1'b0;
                ctrl_q   <= CTRL_BUBBLE;
            end else begin
                ex_valid <= 1'b1;
                ctrl_q   <= dec_ctrl;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_illegal <= 1'b0;
        end else begin
            ex_illegal <= dec_illegal && id_valid && !flush && !stall_out;
        end
    end
`endif

    assign ex_ALUOp    = ctrl_q.alu_op;
    assign ex_Funct    = ctrl_q.funct;
    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_MemRead  = ctrl_q.mem_read;
    assign ex_MemWrite = ctrl_q.mem_write;
    assign ex_MemtoReg = ctrl_q.mem_to_reg;
    assign ex_ALUSrc   = ctrl_q.alu_src;
    assign ex_Branch   = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Scoreboard bench for id_ex_control_stage: directed plan plus random stream.
// Honours ILLEGAL_TRAP_EN when defined.
module tb_id_ex_control_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        flush;
    logic        stall_out;
    logic        ex_valid;
    logic [1:0]  ex_ALUOp;
    logic [3:0]  ex_Funct;
    logic        ex_RegWrite, ex_MemRead, ex_MemWrite;
    logic        ex_MemtoReg, ex_ALUSrc, ex_Branch;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ill_sig;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
    logic ex_illegal;
    assign ill_sig = ex_illegal;
`else
    localparam bit TRAP = 1'b0;
    assign ill_sig = 1'b0;
`endif

    id_ex_control_stage #(.XLEN_IDX(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .flush       (flush),
        .stall_out   (stall_out),
        .ex_valid    (ex_valid),
        .ex_ALUOp    (ex_ALUOp),
        .ex_Funct    (ex_Funct),
        .ex_RegWrite (ex_RegWrite),
        .ex_MemRead  (ex_MemRead),
        .ex_MemWrite (ex_MemWrite),
        .ex_MemtoReg (ex_MemtoReg),
        .ex_ALUSrc   (ex_ALUSrc),
        .ex_Branch   (ex_Branch),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd)
`ifdef ILLEGAL_TRAP_EN
        ,
        .ex_illegal  (ex_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic [1:0] aluop;
        logic [3:0] funct;
        logic       rw, mr, mw, m2r, as, br;
        logic [4:0] rs1, rs2, rd;
        logic       ill;
    } exp_t;

    exp_t out_q[$];
    logic stall_q[$];
    int   total = 0;
    int   bad   = 0;

    logic       m_valid = 1'b0;
    logic       m_mr    = 1'b0;
    logic [4:0] m_rd    = 5'd0;
    logic       last_stall = 1'b0;

    // Architectural decode rules, expressed instruction class by class.
    function automatic void ref_ctrl(input logic [31:0] ins, output exp_t e,
                                     output logic ill, output logic use2);
        logic [3:0] fc;
        fc   = {ins[30], ins[14:12]};
        e    = '0;
        ill  = 1'b0;
        use2 = 1'b0;
        case (ins[6:0])
            7'h33: begin
                use2 = 1'b1;
                ill = !(fc == 4'h0 || fc == 4'h8 || fc == 4'h7 || fc == 4'h6);
                e.aluop = 2'd2; e.funct = fc; e.rw = 1'b1;
            end
            7'h13: begin
                ill = ins[14:12] > 3'd1;
                e.funct = (ins[14:12] == 3'd1) ? 4'd1 : 4'd0;
                e.as = 1'b1; e.rw = 1'b1;
            end
            7'h03: begin
                e.as = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1;
            end
            7'h23: begin
                use2 = 1'b1; e.as = 1'b1; e.mw = 1'b1;
            end
            7'h63: begin
                use2 = 1'b1; e.aluop = 2'd1; e.funct = fc; e.br = 1'b1;
            end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic step(input logic r, input logic v,
                        input logic [31:0] ins, input logic fl);
        exp_t d, e;
        logic ill, u2, st;
        @(negedge clk);
        reset = r; id_valid = v; id_instr = ins; flush = fl;
        ref_ctrl(ins, d, ill, u2);
        st = m_valid && m_mr && (m_rd != 5'd0) && v && !fl &&
             ((m_rd == ins[19:15]) || (u2 && (m_rd == ins[24:20])));
        stall_q.push_back(st);
        last_stall = st;
        e = '0;
        if (r) begin
            if (fl || st || !v || ill) begin
                e.ill = TRAP && ill && v && !fl && !st;
            end else begin
                e = d;
                e.valid = 1'b1;
            end
            e.rs1 = ins[19:15];
            e.rs2 = ins[24:20];
            e.rd  = ins[11:7];
        end
        out_q.push_back(e);
        m_valid = e.valid;
        m_mr    = e.mr;
        m_rd    = e.rd;
    endtask

    initial begin : out_monitor
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (out_q.size() > 0) begin
                e = out_q.pop_front();
                a = {ex_valid, ex_ALUOp, ex_Funct, ex_RegWrite, ex_MemRead,
                     ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch,
                     ex_rs1, ex_rs2, ex_rd, ill_sig};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL ex_bundle t=%0t got=%h want=%h",
                             $time, a, e);
                end
            end
        end
    end

    initial begin : stall_monitor
        logic s;
        forever begin
            @(negedge clk);
            #2;
            if (stall_q.size() > 0) begin
                s = stall_q.pop_front();
                total++;
                if (stall_out !== s) begin
                    bad++;
                    $display("FAIL stall_out t=%0t got=%b want=%b",
                             $time, stall_out, s);
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] ins, held;
        logic [6:0]  op;
        logic        v, fl, r;
        reset = 1'b0; id_valid = 1'b1; id_instr = 32'h002081B3; flush = 1'b0;
        @(posedge clk);
        step(1'b0, 1'b1, 32'h002081B3, 1'b0);
        step(1'b1, 1'b1, 32'h002081B3, 1'b0);
        step(1'b1, 1'b1, 32'h402081B3, 1'b0);
        step(1'b1, 1'b1, 32'h00109093, 1'b0);
        step(1'b1, 1'b1, 32'h00208063, 1'b0);
        step(1'b1, 1'b1, 32'h0000B283, 1'b0);
        step(1'b1, 1'b1, 32'h00228333, 1'b0);
        step(1'b1, 1'b1, 32'h00228333, 1'b0);
        step(1'b1, 1'b1, 32'h0000B283, 1'b0);
        step(1'b1, 1'b1, 32'h00228333, 1'b1);
        step(1'b1, 1'b0, 32'h00000000, 1'b0);
        step(1'b1, 1'b1, 32'h0020C1B3, 1'b0);
        step(1'b1, 1'b1, 32'h00208063, 1'b0);
        step(1'b1, 1'b1, 32'h0000B003, 1'b0);
        step(1'b1, 1'b1, 32'h00000333, 1'b0);
        step(1'b1, 1'b1, 32'h0000B283, 1'b0);
        step(1'b1, 1'b1, 32'h0002B303, 1'b0);
        step(1'b1, 1'b1, 32'h0002B303, 1'b0);
        step(1'b1, 1'b1, 32'h00530393, 1'b0);
        step(1'b1, 1'b1, 32'h0000B283, 1'b0);
        step(1'b0, 1'b1, 32'h00228333, 1'b0);
        step(1'b1, 1'b1, 32'h00228333, 1'b0);

        held = 32'h0;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    op = 7'h03;
                2:       op = 7'h33;
                3:       op = 7'h13;
                4:       op = 7'h23;
                5:       op = 7'h63;
                6:       op = 7'h33;
                default: op = 7'($urandom);
            endcase
            ins = {1'b0, 1'($urandom), 5'b0,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   3'($urandom), 5'($urandom_range(0, 3)), op};
            v  = ($urandom_range(0, 99) < 88);
            fl = ($urandom_range(0, 99) < 8);
            r  = ($urandom_range(0, 99) >= 2);
            if (last_stall) begin
                ins = held;
                v   = 1'b1;
            end
            held = ins;
            step(r, v, ins, fl);
        end

        repeat (3) @(negedge clk);
        total++;
        if (out_q.size() != 0 || stall_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d want=0/0",
                     out_q.size(), stall_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
